// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter : two-port writeback arbiter for the register file write
//                      port, with a pending-write scoreboard for RAW checks.
// Revision 1.0
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter bit FAIR   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r0_valid_i,
  output logic                 r0_ready_o,
  input  logic [REG_AW-1:0]    r0_dest_i,
  input  logic [DATA_W-1:0]    r0_data_i,
  input  logic                 r0_hb_i,
  input  logic                 r0_lb_i,
  input  logic                 r1_valid_i,
  output logic                 r1_ready_o,
  input  logic [REG_AW-1:0]    r1_dest_i,
  input  logic [DATA_W-1:0]    r1_data_i,
  input  logic                 r1_hb_i,
  input  logic                 r1_lb_i,
  input  logic                 rsv_valid_i,
  input  logic [REG_AW-1:0]    rsv_reg_i,
  input  logic [REG_AW-1:0]    chkA_i,
  input  logic [REG_AW-1:0]    chkB_i,
  output logic                 hazA_o,
  output logic                 hazB_o,
  output logic [2**REG_AW-1:0] pending_o,
  output logic                 rf_we_o,
  output logic [REG_AW-1:0]    rf_regDest_o,
  output logic [DATA_W-1:0]    rf_dataIn_o,
  output logic                 rf_hb_o,
  output logic                 rf_lb_o
);

  localparam int NREG = 2**REG_AW;

  logic              gnt0, gnt1;
  logic              last_grant_q;
  logic              rf_we_q;
  logic [REG_AW-1:0] rf_dest_q, rf_dest_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              rf_hb_q, rf_hb_d;
  logic              rf_lb_q, rf_lb_d;
  logic [NREG-1:0]   pending_q, pending_d;

  // last_grant_q = 1 means port 1 won most recently, so port 0 is preferred next.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (r0_valid_i && r1_valid_i) begin
        if (FAIR && !last_grant_q) gnt1 = 1'b1;
        else                       gnt0 = 1'b1;
      end else begin
        gnt0 = r0_valid_i;
        gnt1 = r1_valid_i;
      end
    end
  end

  always_comb begin
    rf_dest_d = rf_dest_q;
    rf_data_d = rf_data_q;
    rf_hb_d   = rf_hb_q;
    rf_lb_d   = rf_lb_q;
    if (gnt0) begin
      rf_dest_d = r0_dest_i;
      rf_data_d = r0_data_i;
      rf_hb_d   = r0_hb_i;
      rf_lb_d   = r0_lb_i;
    end else if (gnt1) begin
      rf_dest_d = r1_dest_i;
      rf_data_d = r1_data_i;
      rf_hb_d   = r1_hb_i;
      rf_lb_d   = r1_lb_i;
    end
  end

  // Clear happens after the regFile commit; a same-edge reserve overrides it.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) pending_d[rf_dest_q] = 1'b0;
    if (rsv_valid_i) pending_d[rsv_reg_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q      <= 1'b0;
      rf_dest_q    <= '0;
      rf_data_q    <= '0;
      rf_hb_q      <= 1'b0;
      rf_lb_q      <= 1'b0;
      last_grant_q <= 1'b1;
      pending_q    <= '0;
    end else begin
      rf_we_q   <= gnt0 | gnt1;
      rf_dest_q <= rf_dest_d;
      rf_data_q <= rf_data_d;
      rf_hb_q   <= rf_hb_d;
      rf_lb_q   <= rf_lb_d;
      pending_q <= pending_d;
      if (gnt0)      last_grant_q <= 1'b0;
      else if (gnt1) last_grant_q <= 1'b1;
    end
  end

  // A transfer still in the output stage when reset arrives must not reach the regFile.
  assign rf_we_o      = rf_we_q & ~rst;
  assign rf_regDest_o = rf_dest_q;
  assign rf_dataIn_o  = rf_data_q;
  assign rf_hb_o      = rf_hb_q;
  assign rf_lb_o      = rf_lb_q;
  assign r0_ready_o   = gnt0;
  assign r1_ready_o   = gnt1;
  assign pending_o    = pending_q;
  assign hazA_o       = pending_q[chkA_i];
  assign hazB_o       = pending_q[chkB_i];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_arbiter : directed bench for regfile_wb_arbiter (FAIR=1 and FAIR=0).
// Revision 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_clr;
  logic        r0_valid, r0_hb, r0_lb, r1_valid, r1_hb, r1_lb;
  logic [2:0]  r0_dest, r1_dest, rsv_reg, chkA, chkB;
  logic [15:0] r0_data, r1_data;
  logic        rsv_valid;

  logic        r0_ready, r1_ready, hazA, hazB, rf_we, rf_hb, rf_lb;
  logic [7:0]  pending;
  logic [2:0]  rf_dest;
  logic [15:0] rf_data;

  logic        f_r0_ready, f_r1_ready, f_hazA, f_hazB, f_we, f_hb, f_lb;
  logic [7:0]  f_pending;
  logic [2:0]  f_dest;
  logic [15:0] f_data;

  regfile_wb_arbiter #(.DATA_W(16), .REG_AW(3), .FAIR(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .r0_valid_i(r0_valid), .r0_ready_o(r0_ready), .r0_dest_i(r0_dest), .r0_data_i(r0_data),
    .r0_hb_i(r0_hb), .r0_lb_i(r0_lb),
    .r1_valid_i(r1_valid), .r1_ready_o(r1_ready), .r1_dest_i(r1_dest), .r1_data_i(r1_data),
    .r1_hb_i(r1_hb), .r1_lb_i(r1_lb),
    .rsv_valid_i(rsv_valid), .rsv_reg_i(rsv_reg), .chkA_i(chkA), .chkB_i(chkB),
    .hazA_o(hazA), .hazB_o(hazB), .pending_o(pending),
    .rf_we_o(rf_we), .rf_regDest_o(rf_dest), .rf_dataIn_o(rf_data), .rf_hb_o(rf_hb), .rf_lb_o(rf_lb)
  );

  regfile_wb_arbiter #(.DATA_W(16), .REG_AW(3), .FAIR(1'b0)) u_fix (
    .clk(clk), .rst(rst),
    .r0_valid_i(r0_valid), .r0_ready_o(f_r0_ready), .r0_dest_i(r0_dest), .r0_data_i(r0_data),
    .r0_hb_i(r0_hb), .r0_lb_i(r0_lb),
    .r1_valid_i(r1_valid), .r1_ready_o(f_r1_ready), .r1_dest_i(r1_dest), .r1_data_i(r1_data),
    .r1_hb_i(r1_hb), .r1_lb_i(r1_lb),
    .rsv_valid_i(rsv_valid), .rsv_reg_i(rsv_reg), .chkA_i(chkA), .chkB_i(chkB),
    .hazA_o(f_hazA), .hazB_o(f_hazB), .pending_o(f_pending),
    .rf_we_o(f_we), .rf_regDest_o(f_dest), .rf_dataIn_o(f_data), .rf_hb_o(f_hb), .rf_lb_o(f_lb)
  );

  // Behavioural regFile driven by the FAIR=1 instance's write port.
  logic [15:0] mem [8];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 8; k++) mem[k] <= 16'h0000;
    end else if (rf_we) begin
      if (rf_hb) mem[rf_dest][15:8] <= rf_data[15:8];
      if (rf_lb) mem[rf_dest][7:0]  <= rf_data[7:0];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r0v; logic [2:0] d0; logic [15:0] x0; logic hb0; logic lb0;
    logic        r1v; logic [2:0] d1; logic [15:0] x1; logic hb1; logic lb1;
    logic        er0; logic er1; logic ef0; logic ef1;
    logic        ewe; logic [2:0] edest; logic [15:0] edata; logic ehb; logic elb;
    logic        cm;  logic [2:0] mreg; logic [15:0] mval;
  } vec_t;

  vec_t vecs [11];

  initial begin
    // single write, commit check, contention, byte lanes, zero-enable write
    vecs[0]  = '{1'b1,3'd1,16'hDEAD,1'b1,1'b1, 1'b0,3'd0,16'h0000,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 1'b1,3'd1,16'hDEAD,1'b1,1'b1, 1'b0,3'd0,16'h0000};
    vecs[1]  = '{1'b0,3'd0,16'h0000,1'b0,1'b0, 1'b0,3'd0,16'h0000,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,3'd1,16'hDEAD,1'b1,1'b1, 1'b1,3'd1,16'hDEAD};
    vecs[2]  = '{1'b1,3'd2,16'hBEEF,1'b1,1'b1, 1'b1,3'd7,16'hFFCC,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b0, 1'b1,3'd7,16'hFFCC,1'b1,1'b1, 1'b0,3'd0,16'h0000};
    vecs[3]  = '{1'b1,3'd2,16'hBEEF,1'b1,1'b1, 1'b1,3'd7,16'hFFCC,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0, 1'b1,3'd2,16'hBEEF,1'b1,1'b1, 1'b1,3'd7,16'hFFCC};
    vecs[4]  = '{1'b1,3'd2,16'hBEEF,1'b1,1'b1, 1'b1,3'd7,16'hFFCC,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b0, 1'b1,3'd7,16'hFFCC,1'b1,1'b1, 1'b1,3'd2,16'hBEEF};
    vecs[5]  = '{1'b1,3'd2,16'hBEEF,1'b1,1'b1, 1'b1,3'd7,16'hFFCC,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0, 1'b1,3'd2,16'hBEEF,1'b1,1'b1, 1'b1,3'd7,16'hFFCC};
    vecs[6]  = '{1'b0,3'd0,16'h0000,1'b0,1'b0, 1'b1,3'd2,16'h9876,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b1, 1'b1,3'd2,16'h9876,1'b0,1'b1, 1'b1,3'd2,16'hBEEF};
    vecs[7]  = '{1'b0,3'd0,16'h0000,1'b0,1'b0, 1'b1,3'd2,16'h2345,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b1, 1'b1,3'd2,16'h2345,1'b1,1'b0, 1'b1,3'd2,16'hBE76};
    vecs[8]  = '{1'b0,3'd0,16'h0000,1'b0,1'b0, 1'b1,3'd2,16'h1111,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, 1'b1,3'd2,16'h1111,1'b0,1'b0, 1'b1,3'd2,16'h2376};
    vecs[9]  = '{1'b0,3'd0,16'h0000,1'b0,1'b0, 1'b0,3'd0,16'h0000,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,3'd2,16'h1111,1'b0,1'b0, 1'b1,3'd2,16'h2376};
    vecs[10] = '{1'b0,3'd0,16'h0000,1'b0,1'b0, 1'b0,3'd0,16'h0000,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,3'd2,16'h1111,1'b0,1'b0, 1'b1,3'd2,16'h2376};

    rst = 1'b1; mem_clr = 1'b1;
    r0_valid = 1'b1; r0_dest = 3'd0; r0_data = 16'h0; r0_hb = 1'b0; r0_lb = 1'b0;
    r1_valid = 1'b0; r1_dest = 3'd0; r1_data = 16'h0; r1_hb = 1'b0; r1_lb = 1'b0;
    rsv_valid = 1'b0; rsv_reg = 3'd0; chkA = 3'd0; chkB = 3'd0;

    #2;
    chk("rst_r0_ready", r0_ready, 1'b0);
    chk("rst_fix_r0_ready", f_r0_ready, 1'b0);
    tick();
    tick();
    chk("rst_r0_ready_2", r0_ready, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_pending", pending, 8'h00);
    chk("rst_rf_dest", rf_dest, 3'd0);
    chk("rst_rf_data", rf_data, 16'h0000);
    chk("rst_rf_hblb", {rf_hb, rf_lb}, 2'b00);
    rst = 1'b0; mem_clr = 1'b0;

    for (int i = 0; i < 11; i++) begin
      r0_valid = vecs[i].r0v; r0_dest = vecs[i].d0; r0_data = vecs[i].x0;
      r0_hb = vecs[i].hb0; r0_lb = vecs[i].lb0;
      r1_valid = vecs[i].r1v; r1_dest = vecs[i].d1; r1_data = vecs[i].x1;
      r1_hb = vecs[i].hb1; r1_lb = vecs[i].lb1;
      #1;
      chk($sformatf("v%0d_ready", i), {r0_ready, r1_ready}, {vecs[i].er0, vecs[i].er1});
      chk($sformatf("v%0d_fix_ready", i), {f_r0_ready, f_r1_ready}, {vecs[i].ef0, vecs[i].ef1});
      tick();
      chk($sformatf("v%0d_rf_we", i), rf_we, vecs[i].ewe);
      chk($sformatf("v%0d_rf_dest", i), rf_dest, vecs[i].edest);
      chk($sformatf("v%0d_rf_data", i), rf_data, vecs[i].edata);
      chk($sformatf("v%0d_rf_hblb", i), {rf_hb, rf_lb}, {vecs[i].ehb, vecs[i].elb});
      if (vecs[i].cm) chk($sformatf("v%0d_mem", i), mem[vecs[i].mreg], vecs[i].mval);
    end

    // Scoreboard: reserve, hazard, clear-after-commit, same-edge set wins.
    rsv_valid = 1'b1; rsv_reg = 3'd3; chkA = 3'd3; chkB = 3'd5;
    #1;
    chk("sb_hazA_pre", hazA, 1'b0);
    tick();
    rsv_reg = 3'd5;
    #1;
    chk("sb_hazA_set", hazA, 1'b1);
    chk("sb_pending_3", pending, 8'h08);
    tick();
    rsv_valid = 1'b0;
    #1;
    chk("sb_pending_35", pending, 8'h28);
    chk("sb_hazB_set", hazB, 1'b1);
    r0_valid = 1'b1; r0_dest = 3'd3; r0_data = 16'hAAAA; r0_hb = 1'b1; r0_lb = 1'b1;
    #1;
    chk("sb_r0_ready", r0_ready, 1'b1);
    tick();
    r0_valid = 1'b0; rsv_valid = 1'b1; rsv_reg = 3'd3;
    #1;
    chk("sb_we_3", rf_we, 1'b1);
    chk("sb_hazA_at_accept", hazA, 1'b1);
    tick();
    rsv_valid = 1'b0;
    #1;
    chk("sb_set_wins", pending, 8'h28);
    chk("sb_hazA_kept", hazA, 1'b1);
    r1_valid = 1'b1; r1_dest = 3'd5; r1_data = 16'h5555; r1_hb = 1'b1; r1_lb = 1'b1;
    tick();
    r1_valid = 1'b0;
    #1;
    chk("sb_we_5", rf_we, 1'b1);
    chk("sb_hazB_during_we", hazB, 1'b1);
    tick();
    chk("sb_clear_5", pending, 8'h08);
    chk("sb_hazB_clear", hazB, 1'b0);
    r0_valid = 1'b1; r0_dest = 3'd3;
    tick();
    r0_valid = 1'b0;
    #1;
    chk("sb_hazA_until_commit", hazA, 1'b1);
    tick();
    chk("sb_clear_3", pending, 8'h00);
    chk("sb_hazA_clear", hazA, 1'b0);
    chk("sb_mem5", mem[5], 16'h5555);

    // Reset arriving while an accepted write sits in the output stage.
    rsv_valid = 1'b1; rsv_reg = 3'd4;
    tick();
    rsv_valid = 1'b0;
    r0_valid = 1'b1; r0_dest = 3'd4; r0_data = 16'h1234; r0_hb = 1'b1; r0_lb = 1'b1;
    #1;
    chk("mr_pending_4", pending, 8'h10);
    chk("mr_r0_ready", r0_ready, 1'b1);
    tick();
    r0_valid = 1'b0; rst = 1'b1;
    #1;
    chk("mr_we_gated", rf_we, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("mr_we", rf_we, 1'b0);
    chk("mr_pending", pending, 8'h00);
    tick();
    chk("mr_we_after", rf_we, 1'b0);
    chk("mr_mem4", mem[4], 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
